uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, clock cycles per bit (27 MHz / 234 = 115200 baud); legal range >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, LSB first; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1..2.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 uart_rx  input  1  asynchronous serial line; idles high.
REQ-008 rx_data  output  DATA_BITS  received word; valid while rx_valid=1.
REQ-009 rx_valid  output  1  word available; held until accepted.
REQ-010 rx_ready  input  1  consumer accepts when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-011 frame_err  output  1  stop-bit error tag for the current rx_data; valid with rx_valid.
REQ-012 parity_err  output  1  parity error tag for the current rx_data; 0 when PARITY=0.
REQ-013 overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-014 uart_rx SHALL pass through a 2-flop synchronizer; every reference to "line" below means the synchronized value.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-016 IDLE: when the line is 0, SHALL enter START with counter=1.
REQ-017 START: at counter=CLKS_PER_BIT/2 (integer divide), SHALL sample the line.
  - Line 0: enter DATA with counter reset.
  - Line 1 (glitch): return to IDLE, no output activity.
REQ-018 DATA: SHALL sample each bit when the counter reaches CLKS_PER_BIT after the previous sample, then shift it in LSB first.
  - After DATA_BITS samples: go to PARITY if PARITY!=0, else to STOP.
REQ-019 PARITY: SHALL sample one bit CLKS_PER_BIT after the last data sample.
  - Error when (XOR of data bits and parity bit) is 0 for odd parity, or 1 for even parity.
REQ-020 STOP: SHALL sample STOP_BITS bits, CLKS_PER_BIT apart.
  - frame_err tag = 1 if any sampled stop bit is 0.
  - After the last stop sample: go to IDLE if all stop bits were 1, else to BREAK_WAIT.
REQ-021 BREAK_WAIT: SHALL stay until the line is sampled 1, then go to IDLE; no start detection while in this state.
REQ-022 Word completion SHALL occur on the cycle of the last stop-bit sample; rx_data, frame_err and parity_err SHALL update and rx_valid SHALL be 1 on the next cycle.
REQ-023 A word with errors SHALL still be delivered, carrying its error tags.
REQ-024 Output register handling:
  - rx_valid SHALL drop the cycle after acceptance if no word completes.
  - If acceptance and completion occur in the same cycle, the new word loads, rx_valid stays 1 and overrun stays 0.
REQ-025 If a word completes while rx_valid=1 and rx_ready=0, the new word SHALL be discarded, the held word and its tags SHALL stay unchanged, and overrun SHALL pulse for exactly 1 cycle.
REQ-026 The bit counter SHALL be $clog2(CLKS_PER_BIT+1) bits wide and SHALL never wrap within a bit period.

Reset
REQ-027 While rst=1 the block SHALL hold state=IDLE and counters=0; this takes effect on the first clock edge with rst=1, including mid-frame.
REQ-028 After reset: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, and both synchronizer flops=1.
REQ-029 A frame in progress when rst is asserted SHALL be discarded; reception SHALL resume with the first falling edge after rst is released.

Verification
REQ-030 Default parameters, 8N1 0xA5, rx_ready=1 -> rx_data=0xA5 for 1 cycle with rx_valid=1 and both error tags 0.
REQ-031 CLKS_PER_BIT=16, PARITY=2, byte 0x03 sent with parity bit 1 -> rx_data=0x03, parity_err=1; the same byte with parity bit 0 -> parity_err=0.
REQ-032 CLKS_PER_BIT=16, line low for 4 cycles then high -> rx_valid stays 0 and the FSM is back in IDLE.
REQ-033 rx_ready=0, bytes 0x11 then 0x22 -> rx_data holds 0x11, overrun pulses once; raising rx_ready then clears rx_valid.
REQ-034 Line low for 20 bit-times -> one word 0x00 with frame_err=1, no further words until the line is high and a new start bit arrives.
REQ-035 rst pulsed during data bit 4 of a frame -> all outputs 0, no partial word delivered; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver: 2-flop line synchronizer, mid-bit sampling FSM,
// optional odd/even parity, 1-2 stop bits, and a ready/valid output holding register.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL   = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } word_t;

  // line synchronizer; resets to the idle (high) level
  logic [1:0] sync_pipe;
  logic       line;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= 2'b11;
    else     sync_pipe <= {sync_pipe[0], uart_rx};
  end
  assign line = sync_pipe[1];

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q;
  logic                 tick, done;
  word_t                word, out_q;

  // cnt holds cycles since the previous sample, so a full period ends at FULL
  assign tick = (cnt == FULL);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!line) state_nxt = S_START;
      S_START:  if (cnt == HALF) state_nxt = line ? S_IDLE : S_DATA;
      S_DATA:   if (tick && idx == LAST_D) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (tick && idx == LAST_S) state_nxt = (ferr_q || !line) ? S_BREAK : S_IDLE;
      S_BREAK:  if (line) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done      = (state == S_STOP) && tick && (idx == LAST_S);
    word.data = shreg;
    word.ferr = ferr_q | ~line;
    word.perr = perr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt    <= line ? '0 : ONE;
          idx    <= '0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
        end
        S_START: cnt <= (cnt == HALF) ? ONE : cnt + ONE;
        S_DATA: begin
          cnt <= tick ? ONE : cnt + ONE;
          if (tick) begin
            shreg <= {line, shreg[DATA_BITS-1:1]};
            idx   <= (idx == LAST_D) ? '0 : idx + IW'(1);
          end
        end
        S_PARITY: begin
          cnt <= tick ? ONE : cnt + ONE;
          if (tick) perr_q <= (PARITY == 1) ? ~(^shreg ^ line) : (^shreg ^ line);
        end
        S_STOP: begin
          cnt <= tick ? ONE : cnt + ONE;
          if (tick) begin
            ferr_q <= ferr_q | ~line;
            idx    <= idx + IW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // a completing word is dropped only when the held word is not being taken
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          out_q    <= word;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = out_q.data;
  assign frame_err  = out_q.ferr;
  assign parity_err = out_q.perr;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven by a frame-level serial
// model; received words are scoreboarded against expectations derived from the frame.
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int NCH = 3;
  localparam int CPB [NCH] = '{234, 16, 10};
  localparam int DB  [NCH] = '{8, 8, 7};
  localparam int PAR [NCH] = '{0, 2, 1};
  localparam int SB  [NCH] = '{1, 1, 2};

  logic [NCH-1:0] line, ready, valid, ferr, perr, ovr;
  logic [7:0]     data_a, data_b;
  logic [6:0]     data_c;
  logic [8:0]     data [NCH];

  always_comb begin
    data[0] = 9'(data_a);
    data[1] = 9'(data_b);
    data[2] = 9'(data_c);
  end

  uart_rx_param dut_a (
    .clk(clk), .rst(rst), .uart_rx(line[0]), .rx_data(data_a), .rx_valid(valid[0]),
    .rx_ready(ready[0]), .frame_err(ferr[0]), .parity_err(perr[0]), .overrun(ovr[0]));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(line[1]), .rx_data(data_b), .rx_valid(valid[1]),
    .rx_ready(ready[1]), .frame_err(ferr[1]), .parity_err(perr[1]), .overrun(ovr[1]));

  uart_rx_param #(.CLKS_PER_BIT(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .uart_rx(line[2]), .rx_data(data_c), .rx_valid(valid[2]),
    .rx_ready(ready[2]), .frame_err(ferr[2]), .parity_err(perr[2]), .overrun(ovr[2]));

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc  [NCH] = '{default: 0};
  int   vcyc [NCH] = '{default: 0};
  int   ovc  [NCH] = '{default: 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted word must be the next expected one
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (valid[c]) vcyc[c]++;
        if (ovr[c])   ovc[c]++;
        if (valid[c] && ready[c]) begin
          acc[c]++;
          mon_e = '{ch: -1, data: 9'h0, fe: 1'b0, pe: 1'b0};
          if (exp_q.size() != 0) mon_e = exp_q.pop_front();
          chk($sformatf("word_ch%0d", c), 32'(c), 32'(mon_e.ch));
          chk($sformatf("data_ch%0d", c), 32'(data[c]), 32'(mon_e.data));
          chk($sformatf("ferr_ch%0d", c), 32'(ferr[c]), 32'(mon_e.fe));
          chk($sformatf("perr_ch%0d", c), 32'(perr[c]), 32'(mon_e.pe));
        end
      end
    end
  end

  task automatic bit_out(input int c, input logic v);
    line[c] = v;
    repeat (CPB[c]) @(posedge clk);
    #1;
  endtask

  // bad_stop: index of a stop bit forced to 0, or -1 for a clean frame
  task automatic send(input int c, input logic [8:0] d, input bit pflip,
                      input int bad_stop, input bit expect_it, input int gap);
    logic [8:0] dm;
    logic       pb, fe, pe;
    int         ones;
    dm   = d & 9'((1 << DB[c]) - 1);
    ones = $countones(dm);
    pb   = (PAR[c] == 1) ? ~ones[0] : ones[0];
    pb   = pb ^ pflip;
    pe   = (PAR[c] == 1) ? ((ones + int'(pb)) % 2 == 0) :
           (PAR[c] == 2) ? ((ones + int'(pb)) % 2 == 1) : 1'b0;
    fe   = (bad_stop >= 0);
    if (expect_it) exp_q.push_back('{ch: c, data: dm, fe: fe, pe: pe});
    bit_out(c, 1'b0);
    for (int i = 0; i < DB[c]; i++) bit_out(c, dm[i]);
    if (PAR[c] != 0) bit_out(c, pb);
    for (int i = 0; i < SB[c]; i++) bit_out(c, (i == bad_stop) ? 1'b0 : 1'b1);
    for (int i = 0; i < gap; i++) bit_out(c, 1'b1);
  endtask

  // long break: one all-zero word with frame error, then silence until a new start
  task automatic brk(input int c);
    exp_q.push_back('{ch: c, data: 9'h0, fe: 1'b1, pe: (PAR[c] == 1)});
    line[c] = 1'b0;
    repeat (20 * CPB[c]) @(posedge clk);
    #1;
    line[c] = 1'b1;
    repeat (3 * CPB[c]) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, b0;
    logic [7:0] rb;
    line  = '1;
    ready = '1;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("rst_valid%0d", c), 32'(valid[c]), 0);
      chk($sformatf("rst_data%0d", c),  32'(data[c]),  0);
      chk($sformatf("rst_ferr%0d", c),  32'(ferr[c]),  0);
      chk($sformatf("rst_perr%0d", c),  32'(perr[c]),  0);
      chk($sformatf("rst_ovr%0d", c),   32'(ovr[c]),   0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 8N1 0xA5 at the default rate
    send(0, 9'h0A5, 1'b0, -1, 1'b1, 2);
    chk("a5_count", 32'(acc[0]), 1);

    // even parity: 0x03 with a wrong then a correct parity bit
    send(1, 9'h003, 1'b1, -1, 1'b1, 1);
    send(1, 9'h003, 1'b0, -1, 1'b1, 1);
    chk("par_count", 32'(acc[1]), 2);

    // short low glitch must not start a frame; a real frame then follows cleanly
    line[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    line[1] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_valid", 32'(valid[1]), 0);
    chk("glitch_count", 32'(acc[1]), 2);
    send(1, 9'h03C, 1'b0, -1, 1'b1, 1);
    chk("post_glitch_count", 32'(acc[1]), 3);

    // backpressure: second word dropped, first held, single overrun pulse
    ready[1] = 1'b0;
    send(1, 9'h011, 1'b0, -1, 1'b1, 1);
    send(1, 9'h022, 1'b0, -1, 1'b0, 1);
    chk("hold_valid", 32'(valid[1]), 1);
    chk("hold_data", 32'(data_b), 32'h11);
    chk("ovr_pulses", 32'(ovc[1]), 1);
    ready[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_drop_valid", 32'(valid[1]), 0);

    // line held low: one framing-error word, nothing more
    b0 = acc[1];
    brk(1);
    chk("brk_b_count", 32'(acc[1] - b0), 1);
    send(1, 9'h096, 1'b0, -1, 1'b1, 1);
    brk(2);
    send(2, 9'h055, 1'b0, -1, 1'b1, 1);

    // reset during data bit 4 of 0x5A on channel B
    rb = 8'h5A;
    b0 = acc[1];
    bit_out(1, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(1, rb[i]);
    line[1] = rb[4];
    repeat (CPB[1] / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("mid_rst_valid%0d", c), 32'(valid[c]), 0);
      chk($sformatf("mid_rst_data%0d", c),  32'(data[c]),  0);
      chk($sformatf("mid_rst_ferr%0d", c),  32'(ferr[c]),  0);
    end
    rst = 1'b0;
    line[1] = 1'b1;
    repeat (2 * CPB[1]) @(posedge clk);
    #1;
    chk("mid_rst_partial", 32'(acc[1] - b0), 0);
    send(1, 9'h05A, 1'b0, -1, 1'b1, 1);
    chk("after_rst_count", 32'(acc[1] - b0), 1);

    // randomized frames with occasional parity and stop-bit corruption
    a0 = acc[0] + acc[1] + acc[2];
    for (int n = 0; n < 30; n++) begin
      int c, bad;
      bit pf;
      c   = $urandom_range(0, 2);
      pf  = ($urandom_range(0, 3) == 0);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SB[c] - 1)) : -1;
      send(c, 9'($urandom), pf, bad, 1'b1, 1 + $urandom_range(0, 2));
    end
    chk("rand_count", 32'(acc[0] + acc[1] + acc[2] - a0), 30);

    repeat (5) @(posedge clk);
    #1;
    chk("pending", 32'(exp_q.size()), 0);
    chk("ovr_a", 32'(ovc[0]), 0);
    chk("ovr_b", 32'(ovc[1]), 1);
    chk("ovr_c", 32'(ovc[2]), 0);
    chk("pulse_a", 32'(vcyc[0]), 32'(acc[0]));
    chk("pulse_c", 32'(vcyc[2]), 32'(acc[2]));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
